// File: rtl/fpga_robots_game_serial_rx.sv
// Serial receiver for the robots game host link.
// Frame format: 8N1, LSB first. The line is sampled at 8x the baud rate.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   baud8          single-cycle strobe at 8x baud
//   serial_rx      asynchronous serial line from the host, idles high
//   rx_data        last received byte, valid while rx_valid is high
//   rx_valid       byte available; held until rx_ack
//   rx_ack         consumer acknowledge; only honoured while rx_valid is high
//   rx_overrun     one-cycle pulse: a completed byte was dropped because the
//                  previous byte had not been acknowledged
//   rx_framing_err one-cycle pulse: the stop bit was sampled low
module fpga_robots_game_serial_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud8,
  input  logic       serial_rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       rx_framing_err
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHi
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       sync1_q;
  logic       rxs;
  logic       deliver;
  logic       frame_err;

  // Two-flop synchronizer; both flops reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync1_q <= serial_rx;
      rxs     <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    deliver   = 1'b0;
    frame_err = 1'b0;
    if (baud8) begin
      case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_d = StStart;
            cnt_d   = 3'd0;
          end
        end
        StStart: begin
          // Sample mid start bit; a high line here was only a glitch.
          if (cnt_q == 3'd3) begin
            if (rxs) begin
              state_d = StIdle;
            end else begin
              state_d = StData;
              cnt_d   = 3'd0;
              bit_d   = 3'd0;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        StData: begin
          // Counter wraps 7->0, so each data bit is sampled 8 ticks apart.
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            shreg_d = {rxs, shreg_q[7:1]};
            if (bit_q == 3'd7) begin
              state_d = StStop;
              cnt_d   = 3'd0;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        StStop: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            cnt_d = 3'd0;
            if (rxs) begin
              deliver = 1'b1;
              state_d = StIdle;
            end else begin
              frame_err = 1'b1;
              state_d   = StWaitHi;
            end
          end
        end
        StWaitHi: begin
          // Wait out a stuck-low line before hunting for a new start bit.
          if (rxs) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Delivery / acknowledge handshake and the registered error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data        <= 8'h00;
      rx_valid       <= 1'b0;
      rx_overrun     <= 1'b0;
      rx_framing_err <= 1'b0;
    end else begin
      rx_overrun     <= 1'b0;
      rx_framing_err <= frame_err;
      if (deliver) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shreg_q;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpga_robots_game_serial_rx.sv
// Bench for fpga_robots_game_serial_rx: directed scenarios plus random frames.
// Expected events (delivery / overrun / framing error) are queued when a frame
// is issued; a negedge monitor pops and compares them as the DUT reports.
module tb_fpga_robots_game_serial_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud8 = 1'b0;
  logic       serial_rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_framing_err;

  int checks = 0;
  int failures = 0;

  localparam int EvDeliver = 0;
  localparam int EvOverrun = 1;
  localparam int EvFraming = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  bit         model_valid = 1'b0;
  logic [7:0] model_data = 8'h00;

  fpga_robots_game_serial_rx dut (
    .clk            (clk),
    .rst            (rst),
    .baud8          (baud8),
    .serial_rx      (serial_rx),
    .rx_ack         (rx_ack),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_overrun     (rx_overrun),
    .rx_framing_err (rx_framing_err)
  );

  always #5 clk = ~clk;

  // baud8: one cycle high every 4 clocks.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 4;
      baud8 = (ph == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pop_cmp(input int kind, input logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual=kind%0d/%02h required=none", kind, data);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EvDeliver && e.kind == EvDeliver) check("event_data", {24'd0, data}, {24'd0, e.data});
    end
  endtask

  // Monitor
  logic prev_valid = 1'b0, prev_ack = 1'b0, prev_ovr = 1'b0, prev_fe = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
      prev_ovr   = 1'b0;
      prev_fe    = 1'b0;
    end else begin
      // A fresh byte: valid rose, or valid stayed high across an accepted ack.
      if (rx_valid && (!prev_valid || prev_ack)) pop_cmp(EvDeliver, rx_data);
      if (rx_overrun || rx_framing_err) begin
        check("pulses_exclusive", {31'd0, rx_overrun & rx_framing_err}, 32'd0);
        check("pulse_single_cycle", {31'd0, (rx_overrun & prev_ovr) | (rx_framing_err & prev_fe)},
              32'd0);
      end
      if (rx_overrun) pop_cmp(EvOverrun, 8'h00);
      if (rx_framing_err) pop_cmp(EvFraming, 8'h00);
      prev_valid = rx_valid;
      prev_ack   = rx_ack;
      prev_ovr   = rx_overrun;
      prev_fe    = rx_framing_err;
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baud8) @(posedge clk);
    end
  endtask

  // Reference model: what the consumer should observe for one frame.
  task automatic expect_frame(input logic [7:0] d, input bit stop, input bit ack_at_stop);
    ev_t e;
    e.data = d;
    if (!stop) begin
      e.kind = EvFraming;
      if (ack_at_stop) model_valid = 1'b0;
    end else if (model_valid && !ack_at_stop) begin
      e.kind = EvOverrun;
    end else begin
      e.kind      = EvDeliver;
      model_valid = 1'b1;
      model_data  = d;
    end
    exp_q.push_back(e);
  endtask

  // Drives one frame, each bit lasting 8 ticks. The stop bit is sampled on
  // the 77th tick after the start bit is driven; ack_at_stop raises rx_ack in
  // exactly the cycle that tick's edge samples.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit ack_at_stop,
                            input bit chk_lat);
    logic pre;
    wait_ticks(1);
    #1 serial_rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_ticks(8);
      #1 serial_rx = d[i];
    end
    wait_ticks(8);
    #1 serial_rx = stop;
    wait_ticks(4);
    repeat (3) @(posedge clk);
    #1;
    pre = rx_valid;
    if (ack_at_stop) rx_ack = 1'b1;
    @(posedge clk);
    #1 rx_ack = 1'b0;
    if (chk_lat) begin
      check("latency_before_edge", {31'd0, pre}, 32'd0);
      check("latency_after_edge", {31'd0, rx_valid}, 32'd1);
    end
    wait_ticks(3);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_state();
    check("rx_valid", {31'd0, rx_valid}, {31'd0, model_valid});
    if (model_valid) check("rx_data", {24'd0, rx_data}, {24'd0, model_data});
  endtask

  task automatic do_ack();
    wait_drain();
    @(posedge clk);
    #1 rx_ack = 1'b1;
    @(posedge clk);
    #1 rx_ack = 1'b0;
    check("valid_after_ack", {31'd0, rx_valid}, 32'd0);
    if (model_valid) check("data_held_after_ack", {24'd0, rx_data}, {24'd0, model_data});
    model_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_rx_overrun"}, {31'd0, rx_overrun}, 32'd0);
    check({tag, "_rx_framing_err"}, {31'd0, rx_framing_err}, 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    bit         stop, aas;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_ticks(4);

    // Clean 0xA5 with latency check, then ack.
    expect_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    check_state();
    do_ack();

    // Ack while nothing is valid is ignored.
    do_ack();

    // Start-bit glitch: low for 2 ticks only.
    wait_ticks(1);
    #1 serial_rx = 1'b0;
    wait_ticks(2);
    #1 serial_rx = 1'b1;
    wait_ticks(12);
    check_state();
    expect_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    check_state();
    do_ack();

    // Framing error, line held low 20 ticks, then recovery.
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_ticks(20);
    #1 serial_rx = 1'b1;
    wait_ticks(4);
    wait_drain();
    check_state();
    expect_frame(8'h81, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    check_state();
    do_ack();

    // Overrun without ack, then same-cycle ack on the second delivery.
    expect_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    expect_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check_state();
    do_ack();
    expect_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    expect_frame(8'h22, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    wait_drain();
    check_state();

    // Reset during data bit 4 of 0xFF while 0x22 is still pending.
    fork
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      begin
        wait_ticks(43);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_valid = 1'b0;
        model_data  = 8'h00;
        check_reset_outputs("midframe_reset");
      end
    join
    wait_ticks(4);
    check_reset_outputs("after_reset");
    expect_frame(8'h42, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    check_state();
    do_ack();

    // Random frames: data, stop-bit errors, acks and same-cycle acks.
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      aas  = ($urandom_range(0, 3) == 0);
      expect_frame(d, stop, aas);
      send_frame(d, stop, aas, 1'b0);
      if (!stop) begin
        wait_ticks(3);
        #1 serial_rx = 1'b1;
        wait_ticks(2);
      end
      wait_drain();
      check_state();
      if ($urandom_range(0, 1) == 1) do_ack();
    end

    wait_ticks(10);
    check("queue_empty_at_end", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
